// File: rtl/bulls_cows_param_if.sv
`default_nettype none
// ============================================================================
// Module   : bulls_cows_param_if
// Purpose  : Player-facing signal bundle of the Bulls & Cows game core:
//            switch value and confirm button in, eight display words,
//            attempt counter and win/lose flags out.
// Ports    : guess[4*NUM_DIGITS], confirm, d1..d8[6], attempts[7], win, lose
//            master = stimulus side (board top / bench), slave = game core.
// Revision : 1.0  initial release
// ============================================================================
interface bulls_cows_param_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] guess;
    logic                    confirm;
    logic [5:0]              d1, d2, d3, d4, d5, d6, d7, d8;
    logic [6:0]              attempts;
    logic                    win;
    logic                    lose;

    modport master (
        output guess, confirm,
        input  d1, d2, d3, d4, d5, d6, d7, d8, attempts, win, lose
    );

    modport slave (
        input  guess, confirm,
        output d1, d2, d3, d4, d5, d6, d7, d8, attempts, win, lose
    );
endinterface
`default_nettype wire

// File: rtl/bulls_cows_param.sv
`default_nettype none
// ============================================================================
// Module   : bulls_cows_param
// Purpose  : Parametrised Bulls & Cows game core. Validates secret/guess
//            entries, scores guesses, counts attempts, detects win/lose and
//            drives eight registered display words {enable, hex[3:0], dp}.
// Ports    : clock, reset (sync, active-high)
//            bus (slave): guess, confirm in; d1..d8, attempts, win, lose out
// Revision : 1.0  initial release
// ============================================================================
module bulls_cows_param #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_MAX    = 9,
    parameter int MAX_ATTEMPTS = 10
) (
    input  wire logic         clock,
    input  wire logic         reset,
    bulls_cows_param_if.slave bus
);
    typedef enum logic [2:0] {
        S_SET_SECRET = 3'd0,
        S_GUESS      = 3'd1,
        S_RESULT     = 3'd2,
        S_WIN        = 3'd3,
        S_LOSE       = 3'd4,
        S_ERROR      = 3'd5
    } state_t;

    localparam logic [3:0] c_digit_max  = 4'(DIGIT_MAX);
    localparam logic [6:0] c_max_att    = 7'(MAX_ATTEMPTS);
    localparam logic [2:0] c_num_digits = 3'(NUM_DIGITS);
    localparam logic [6:0] c_att_sat    = 7'd99;
    localparam logic [5:0] c_blank      = 6'b0;

    function automatic logic [5:0] f_word(input logic [3:0] hex, input logic dp);
        return {1'b1, hex, dp};
    endfunction

    state_t      r_state, w_state_nx, r_ret, w_ret_nx;
    logic        r_confirm_q, w_edge, w_valid;
    logic [15:0] w_guess16, r_secret, w_secret_nx, r_last_guess, w_last_nx;
    logic [2:0]  w_bulls, w_cows, r_bulls, w_bulls_nx, r_cows, w_cows_nx;
    logic [6:0]  r_attempts, w_att_nx, w_att_inc;
    logic [3:0]  w_tens, w_units;
    logic [15:0] w_dig_src;
    logic        w_dig_dp;
    logic [5:0]  r_disp [8];
    logic [5:0]  w_disp [8];
    logic        r_win, r_lose;

    // Zero-extend so narrower digit counts share the same 4-digit datapath.
    assign w_guess16 = 16'(bus.guess);
    assign w_edge    = bus.confirm & ~r_confirm_q;
    assign w_att_inc = (r_attempts >= c_att_sat) ? c_att_sat : r_attempts + 7'd1;
    assign w_tens    = 4'(r_attempts / 7'd10);
    assign w_units   = 4'(r_attempts % 7'd10);

    // Entry is legal when every digit is in range and no digit repeats.
    always_comb begin
        w_valid = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_guess16[4*i +: 4] > c_digit_max) w_valid = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (w_guess16[4*i +: 4] == w_guess16[4*j +: 4]) w_valid = 1'b0;
            end
        end
    end

    always_comb begin
        w_bulls = 3'd0;
        w_cows  = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            for (int j = 0; j < NUM_DIGITS; j++) begin
                if (w_guess16[4*i +: 4] == r_secret[4*j +: 4]) begin
                    if (i == j) w_bulls = w_bulls + 3'd1;
                    else        w_cows  = w_cows + 3'd1;
                end
            end
        end
    end

    // Next-state and datapath updates; nothing moves without a confirm edge.
    always_comb begin
        w_state_nx  = r_state;
        w_ret_nx    = r_ret;
        w_secret_nx = r_secret;
        w_last_nx   = r_last_guess;
        w_bulls_nx  = r_bulls;
        w_cows_nx   = r_cows;
        w_att_nx    = r_attempts;
        if (w_edge) begin
            case (r_state)
                S_SET_SECRET: begin
                    if (w_valid) begin
                        w_secret_nx = w_guess16;
                        w_state_nx  = S_GUESS;
                    end else begin
                        w_ret_nx   = S_SET_SECRET;
                        w_state_nx = S_ERROR;
                    end
                end
                S_GUESS: begin
                    if (!w_valid) begin
                        w_ret_nx   = S_GUESS;
                        w_state_nx = S_ERROR;
                    end else begin
                        w_last_nx  = w_guess16;
                        w_bulls_nx = w_bulls;
                        w_cows_nx  = w_cows;
                        w_att_nx   = w_att_inc;
                        if (w_bulls == c_num_digits)
                            w_state_nx = S_WIN;
                        else if (MAX_ATTEMPTS != 0 && w_att_inc == c_max_att)
                            w_state_nx = S_LOSE;
                        else
                            w_state_nx = S_RESULT;
                    end
                end
                S_RESULT: w_state_nx = S_GUESS;
                S_ERROR:  w_state_nx = r_ret;
                S_WIN, S_LOSE: begin
                    w_state_nx = S_SET_SECRET;
                    w_att_nx   = 7'd0;
                    w_bulls_nx = 3'd0;
                    w_cows_nx  = 3'd0;
                end
                default: w_state_nx = S_SET_SECRET;
            endcase
        end
    end

    // Display content for the current state; registered below.
    always_comb begin
        for (int p = 0; p < 8; p++) w_disp[p] = c_blank;
        w_dig_src = w_guess16;
        w_dig_dp  = 1'b0;
        case (r_state)
            S_SET_SECRET: w_disp[7] = f_word(4'h5, 1'b0);
            S_GUESS: begin
                w_disp[7] = f_word(w_tens, 1'b0);
                w_disp[6] = f_word(w_units, 1'b0);
            end
            S_RESULT: begin
                w_disp[7] = f_word({1'b0, r_bulls}, 1'b1);
                w_disp[6] = f_word({1'b0, r_cows}, 1'b0);
                w_disp[5] = f_word(w_tens, 1'b0);
                w_disp[4] = f_word(w_units, 1'b0);
                w_dig_src = r_last_guess;
            end
            S_WIN, S_LOSE: begin
                w_disp[7] = f_word((r_state == S_WIN) ? 4'hA : 4'hF, 1'b0);
                w_disp[5] = f_word(w_tens, 1'b0);
                w_disp[4] = f_word(w_units, 1'b0);
                w_dig_src = r_secret;
                w_dig_dp  = (r_state == S_WIN);
            end
            S_ERROR: ;
            default: ;
        endcase
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_disp[i] = f_word(w_dig_src[4*i +: 4], w_dig_dp);
        end
        if (r_state == S_ERROR) begin
            for (int p = 0; p < 8; p++) w_disp[p] = f_word(4'hE, 1'b0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_SET_SECRET;
            r_ret        <= S_SET_SECRET;
            r_confirm_q  <= 1'b0;
            r_secret     <= 16'd0;
            r_last_guess <= 16'd0;
            r_bulls      <= 3'd0;
            r_cows       <= 3'd0;
            r_attempts   <= 7'd0;
            r_win        <= 1'b0;
            r_lose       <= 1'b0;
            for (int p = 0; p < 8; p++) r_disp[p] <= c_blank;
        end else begin
            r_state      <= w_state_nx;
            r_ret        <= w_ret_nx;
            r_confirm_q  <= bus.confirm;
            r_secret     <= w_secret_nx;
            r_last_guess <= w_last_nx;
            r_bulls      <= w_bulls_nx;
            r_cows       <= w_cows_nx;
            r_attempts   <= w_att_nx;
            r_win        <= (r_state == S_WIN);
            r_lose       <= (r_state == S_LOSE);
            for (int p = 0; p < 8; p++) r_disp[p] <= w_disp[p];
        end
    end

    assign bus.d1       = r_disp[0];
    assign bus.d2       = r_disp[1];
    assign bus.d3       = r_disp[2];
    assign bus.d4       = r_disp[3];
    assign bus.d5       = r_disp[4];
    assign bus.d6       = r_disp[5];
    assign bus.d7       = r_disp[6];
    assign bus.d8       = r_disp[7];
    assign bus.attempts = r_attempts;
    assign bus.win      = r_win;
    assign bus.lose     = r_lose;
endmodule
`default_nettype wire
